// File: rtl/digit_serial_adder.sv
// Multi-cycle two's-complement adder/subtractor, DIGIT bits per clock over WIDTH-bit operands.
// Optional feature: define ADDER_ACCUM_EN to let acc=1 take operand A from the current sum.
module digit_serial_adder #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic             acc,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);
    localparam int N  = WIDTH / DIGIT;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_a, r_b, r_ps;
    logic             r_c;
    logic [CW-1:0]    r_cnt;
    logic             r_amsb, r_bmsb;

    logic [WIDTH-1:0]       w_opa, w_opb;
    logic [DIGIT:0]         w_dsum;
    logic [WIDTH+DIGIT-1:0] w_cat;
    logic [WIDTH-1:0]       w_ps_next;
    logic                   w_last;

`ifdef ADDER_ACCUM_EN
    assign w_opa = acc ? sum : a;
`else
    logic w_unused_acc;
    assign w_unused_acc = acc;
    assign w_opa        = a;
`endif

    assign w_opb  = sub ? ~b : b;
    assign w_dsum = {1'b0, r_a[DIGIT-1:0]} + {1'b0, r_b[DIGIT-1:0]} + {{DIGIT{1'b0}}, r_c};
    // New digit enters at the top; concatenation keeps DIGIT==WIDTH legal.
    assign w_cat     = {w_dsum[DIGIT-1:0], r_ps};
    assign w_ps_next = w_cat[WIDTH+DIGIT-1:DIGIT];
    assign w_last    = (r_cnt == CW'(N - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_ps    <= '0;
            r_c     <= 1'b0;
            r_cnt   <= '0;
            r_amsb  <= 1'b0;
            r_bmsb  <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            sum     <= '0;
            cout    <= 1'b0;
            ovf     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        r_a     <= w_opa;
                        r_b     <= w_opb;
                        r_c     <= sub;
                        r_cnt   <= '0;
                        r_amsb  <= w_opa[WIDTH-1];
                        r_bmsb  <= w_opb[WIDTH-1];
                        busy    <= 1'b1;
                        r_state <= S_RUN;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_RUN: begin
                    r_a   <= r_a >> DIGIT;
                    r_b   <= r_b >> DIGIT;
                    r_c   <= w_dsum[DIGIT];
                    r_ps  <= w_ps_next;
                    r_cnt <= r_cnt + 1'b1;
                    if (w_last) begin
                        sum     <= w_ps_next;
                        cout    <= w_dsum[DIGIT];
                        // Effective B MSB already includes the subtract inversion.
                        ovf     <= (r_amsb == r_bmsb) && (w_ps_next[WIDTH-1] != r_amsb);
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        r_state <= S_DONE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_digit_serial_adder.sv
// Scoreboard bench for digit_serial_adder (WIDTH=8, DIGIT=2).
module tb_digit_serial_adder;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0, sub = 1'b0, acc = 1'b0;
    logic [7:0] a = '0, b = '0;
    logic       busy, done, cout, ovf;
    logic [7:0] sum;

    int checks = 0;
    int errors = 0;
    logic [9:0] sb_q[$];   // {sum, cout, ovf}

    digit_serial_adder #(.WIDTH(8), .DIGIT(2)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .sub(sub), .acc(acc),
        .a(a), .b(b), .busy(busy), .done(done), .sum(sum), .cout(cout), .ovf(ovf)
    );

    always #5 clk = ~clk;

    // Scoreboard: every done pulse pops one expected result.
    always @(negedge clk) begin
        if (rst_n) begin
            checks++;
            if (busy && done) begin
                errors++;
                $display("FAIL busy_done_overlap busy=%0b done=%0b required not both 1", busy, done);
            end
            if (done) begin
                logic [9:0] exp_v;
                checks++;
                if (sb_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_done got sum=%02h cout=%0b ovf=%0b with no pending op", sum, cout, ovf);
                end else begin
                    exp_v = sb_q.pop_front();
                    if ({sum, cout, ovf} !== exp_v) begin
                        errors++;
                        $display("FAIL result got sum=%02h cout=%0b ovf=%0b required sum=%02h cout=%0b ovf=%0b",
                                 sum, cout, ovf, exp_v[9:2], exp_v[1], exp_v[0]);
                    end
                end
            end
        end
    end

    function automatic logic [9:0] model(input logic [7:0] x, input logic [7:0] y, input logic s);
        logic [8:0] r;
        logic       v;
        if (s) r = {1'b0, x} - {1'b0, y} + 9'h100;   // bit 8 = no borrow
        else   r = {1'b0, x} + {1'b0, y};
        if (s) v = (x[7] != y[7]) && (r[7] != x[7]);
        else   v = (x[7] == y[7]) && (r[7] != x[7]);
        return {r[7:0], r[8], v};
    endfunction

    task automatic wait_done(input string name);
        bit seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done) begin seen = 1; break; end
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL %s_timeout done=0 required 1 within 20 cycles", name);
        end
    endtask

    // Drive one op at a negedge; start is sampled on the following posedge.
    task automatic run_op(input string name, input logic [7:0] ia, input logic [7:0] ib,
                          input logic isub, input logic iacc, input logic [9:0] exp_v);
        a = ia; b = ib; sub = isub; acc = iacc; start = 1'b1;
        sb_q.push_back(exp_v);
        @(posedge clk); #1 start = 1'b0; acc = 1'b0;
        wait_done(name);
    endtask

    task automatic test_reset;
        #1;
        checks++;
        if ({busy, done, sum, cout, ovf} !== 12'h000) begin
            errors++;
            $display("FAIL reset_state got busy=%0b done=%0b sum=%02h cout=%0b ovf=%0b required all 0",
                     busy, done, sum, cout, ovf);
        end
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_add_timing;
        int busy_cnt = 0;
        logic [7:0] held;
        a = 8'h3C; b = 8'h15; sub = 1'b0; start = 1'b1;
        sb_q.push_back({8'h51, 1'b0, 1'b0});
        @(posedge clk); #1 start = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (busy) busy_cnt++;
            checks++;
            if (done !== 1'b0) begin
                errors++;
                $display("FAIL add_early_done cycle=%0d done=%0b required 0", k, done);
            end
        end
        checks++;
        if (busy_cnt != 4) begin
            errors++;
            $display("FAIL add_busy_len got %0d cycles required 4", busy_cnt);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL add_done_edge got done=%0b busy=%0b required done=1 busy=0", done, busy);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL add_done_width got done=%0b required 0", done);
        end
        held = sum;
        repeat (3) @(negedge clk);
        checks++;
        if (sum !== 8'h51 || held !== 8'h51) begin
            errors++;
            $display("FAIL add_hold got sum=%02h required 51", sum);
        end
    endtask

    task automatic test_carry_ovf;
        run_op("ff_plus_1", 8'hFF, 8'h01, 1'b0, 1'b0, {8'h00, 1'b1, 1'b0});
        run_op("7f_plus_1", 8'h7F, 8'h01, 1'b0, 1'b0, {8'h80, 1'b0, 1'b1});
    endtask

    task automatic test_subtract;
        run_op("05_minus_07", 8'h05, 8'h07, 1'b1, 1'b0, {8'hFE, 1'b0, 1'b0});
        run_op("80_minus_01", 8'h80, 8'h01, 1'b1, 1'b0, {8'h7F, 1'b1, 1'b1});
    endtask

    task automatic test_start_in_run;
        a = 8'h01; b = 8'h01; sub = 1'b0; start = 1'b1;
        sb_q.push_back({8'h02, 1'b0, 1'b0});
        @(posedge clk); #1 start = 1'b0;
        @(negedge clk); a = 8'h11; start = 1'b1;
        @(negedge clk); start = 1'b0;
        wait_done("start_in_run");
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL start_in_run_relaunch got busy=%0b required 0", busy);
        end
    endtask

    task automatic test_back_to_back;
        a = 8'h10; b = 8'h20; sub = 1'b0; start = 1'b1;
        sb_q.push_back({8'h30, 1'b0, 1'b0});
        sb_q.push_back({8'h30, 1'b0, 1'b0});
        @(posedge clk);
        wait_done("b2b_first");
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            errors++;
            $display("FAIL b2b_busy got busy=%0b done=%0b required busy=1 done=0", busy, done);
        end
        wait_done("b2b_second");
    endtask

    task automatic test_reset_mid_run;
        a = 8'h22; b = 8'h33; sub = 1'b0; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        @(posedge clk); @(posedge clk); #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({busy, done, sum, cout, ovf} !== 12'h000) begin
            errors++;
            $display("FAIL midrun_reset got busy=%0b done=%0b sum=%02h cout=%0b ovf=%0b required all 0",
                     busy, done, sum, cout, ovf);
        end
        @(negedge clk); rst_n = 1'b1;
        repeat (8) @(negedge clk);   // scoreboard flags any spurious done here
        run_op("after_reset", 8'h0A, 8'h0B, 1'b0, 1'b0, {8'h15, 1'b0, 1'b0});
    endtask

    task automatic test_accumulate;
        run_op("acc_seed", 8'h08, 8'h08, 1'b0, 1'b0, {8'h10, 1'b0, 1'b0});
        @(negedge clk);
`ifdef ADDER_ACCUM_EN
        run_op("acc_op", 8'hAA, 8'h05, 1'b0, 1'b1, {8'h15, 1'b0, 1'b0});
`else
        run_op("acc_op", 8'hAA, 8'h05, 1'b0, 1'b1, {8'hAF, 1'b0, 1'b0});
`endif
    endtask

    task automatic test_random;
        logic [7:0] x, y;
        logic       s;
        for (int i = 0; i < 10; i++) begin
            x = 8'($urandom); y = 8'($urandom); s = 1'($urandom);
            run_op("random", x, y, s, 1'b0, model(x, y, s));
        end
    endtask

    initial begin
        test_reset();
        test_add_timing();
        test_carry_ovf();
        test_subtract();
        test_start_in_run();
        test_back_to_back();
        test_reset_mid_run();
        test_accumulate();
        test_random();
        repeat (3) @(negedge clk);
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL pending_results got %0d outstanding required 0", sb_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
